pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central hazard and pipeline-sequencing controller for the 5-stage RISC-V core. It collects stall and redirect requests from ID (load-use), EX (taken branch/jump) and MEM (multi-cycle data access). It drives a per-stage hold vector, a flush pulse and the PC redirect. It also drives the ignore flag carried by the ID/EX register, and keeps saturating stall/flush performance counters.

Parameters:
ADDR_W, 32, PC / branch-target width
MEM_TIMEOUT, 15, max MEM_WAIT cycles before abandoning the access
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the rising edge of clk)
id_load_use_req  in  1  ID needs the result of a load currently in EX
ex_branch_req  in  1  EX resolved a taken branch/jump this cycle
ex_branch_target  in  ADDR_W  redirect target, valid with ex_branch_req
mem_req  in  1  MEM stage starts/continues a data access this cycle
mem_done  in  1  data memory completes the access this cycle
stall_o  out  6  hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] reserved, always 0
flush_o  out  1  clear IF/ID and ID/EX this cycle
pc_redirect_o  out  1  load new_pc_o into PC this cycle
new_pc_o  out  ADDR_W  redirect target, 0 when pc_redirect_o=0
ignore_o  out  1  mark the instruction entering ID/EX as ignored
mem_timeout_o  out  1  one-cycle pulse when an access is abandoned
state_o  out  2  current FSM state, for debug
stall_cnt_o  out  CNT_W  cycles with stall_o[0]=1, saturating
flush_cnt_o  out  CNT_W  flush_o pulses, saturating

Behaviour:
- Stall encoding:
  - Register k holds when stall_o[k]=1.
  - Register k (k>=1) loads a bubble when stall_o[k-1]=1 and stall_o[k]=0.
- Output timing:
  - stall_o, flush_o, pc_redirect_o and new_pc_o are combinational from the registered state and the current inputs. They take effect in the same cycle as the request.
  - ignore_o, mem_timeout_o, state, the wait counter and the perf counters are registered.
- Reset (rst=0 at a clock edge): state=RUN, wait counter=0, ignore_o=0, mem_timeout_o=0, both perf counters=0.
  - While rst=0, all combinational outputs are forced to 0.
  - A reset arriving during MEM_WAIT abandons the access with no timeout pulse.
- FSM states (state_o encoding): RUN=0, MEM_WAIT=1, FLUSH=2, BUBBLE=3.
- RUN, fixed priority MEM > branch > load-use:
  - mem_req=1 and mem_done=0: stall_o=6'b001111. Next state MEM_WAIT, wait counter cleared.
  - mem_req=1 and mem_done=1: single-cycle access, no stall. Branch/load-use are then evaluated as below in the same cycle.
  - ex_branch_req=1: flush_o=1, pc_redirect_o=1, new_pc_o=ex_branch_target. Next state FLUSH.
  - id_load_use_req=1: stall_o=6'b000011, so ID/EX gets a bubble. Next state BUBBLE.
  - Otherwise all outputs 0; stay in RUN.
- MEM_WAIT:
  - stall_o=6'b001111 each cycle; wait counter +1 per cycle.
  - Branch and load-use requests are ignored here; they are held in place and re-presented.
  - mem_done=1: stall_o=0. That cycle is evaluated exactly as RUN for branch/load-use, including their next state; if neither is present, next state RUN.
  - Wait counter reaches MEM_TIMEOUT without mem_done: mem_timeout_o=1 for one cycle, stall released, next state RUN.
- FLUSH (exactly 1 cycle): ignore_o=1, squashing the stale fetch already in flight.
  - All requests are ignored except mem_req, which is handled as in RUN.
  - Next state RUN, or MEM_WAIT if a mem stall starts.
- BUBBLE (exactly 1 cycle): id_load_use_req is ignored, which guarantees one stall per load-use pair.
  - ex_branch_req and mem_req are handled as in RUN.
- Perf counters: stall_cnt_o +1 on each cycle with stall_o[0]=1; flush_cnt_o +1 per flush_o pulse. Both saturate at all-ones with no wrap.

Test Plan:
- Reset sequence: rst=0 for 2 cycles with all requests high -> all outputs 0, state_o=0 (RUN), counters 0.
- Load-use: id_load_use_req=1 held for 2 cycles -> stall_o=000011 in cycle 1 only, state_o=3 then 0, stall_cnt_o=1.
- Branch: ex_branch_req=1, target=0x00000040 -> same cycle flush_o=1, pc_redirect_o=1, new_pc_o=0x40; next cycle ignore_o=1; flush_cnt_o=1.
- Memory wait: mem_req=1, mem_done asserted 4 cycles later with ex_branch_req=1 in the same cycle -> stall_o=001111 for 4 cycles, then redirect taken in the mem_done cycle.
- Timeout: mem_req=1 with mem_done never asserted -> stall for 15 cycles, then mem_timeout_o=1 for one cycle and state_o=0.
- Reset mid-MEM_WAIT: rst=0 at wait cycle 3 -> stall_o=0 immediately, state_o=0, mem_timeout_o stays 0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the hazard controller:
// stage requests flow in, hold/flush/redirect controls flow back out.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              id_load_use_req;
  logic              ex_branch_req;
  logic [ADDR_W-1:0] ex_branch_target;
  logic              mem_req;
  logic              mem_done;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic              pc_redirect_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic              ignore_o;
  logic              mem_timeout_o;

  modport master (
    output id_load_use_req, ex_branch_req, ex_branch_target, mem_req, mem_done,
    input  stall_o, flush_o, pc_redirect_o, new_pc_o, ignore_o, mem_timeout_o
  );

  modport slave (
    input  id_load_use_req, ex_branch_req, ex_branch_target, mem_req, mem_done,
    output stall_o, flush_o, pc_redirect_o, new_pc_o, ignore_o, mem_timeout_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: arbitrates MEM waits,
// EX redirects and ID load-use stalls into hold, flush and redirect controls.
module pipe_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_if.slave       bus,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;
  localparam logic [1:0] ST_BUBBLE   = 2'd3;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000011;
  localparam logic [5:0] STALL_MEM  = 6'b001111;

  // The entry cycle in RUN is the first stall cycle, so the last MEM_WAIT
  // cycle is the one where the counter shows MEM_TIMEOUT-2.
  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_next_s;
  logic              ignore_r;
  logic              timeout_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  logic              mem_stall_s;
  logic              eval_s;
  logic              lu_ok_s;
  logic              timeout_s;
  logic [5:0]        stall_s;
  logic              flush_s;
  logic              redirect_s;
  logic [ADDR_W-1:0] new_pc_s;

  // Memory-side arbitration: decides whether MEM holds the pipe and whether
  // branch/load-use requests get a look this cycle.
  always_comb begin
    mem_stall_s = 1'b0;
    eval_s      = 1'b0;
    lu_ok_s     = 1'b0;
    timeout_s   = 1'b0;
    wait_next_s = wait_cnt_r;
    case (state_r)
      ST_RUN, ST_BUBBLE: begin
        if (bus.mem_req && !bus.mem_done) begin
          mem_stall_s = 1'b1;
          wait_next_s = {WAIT_W{1'b0}};
        end else begin
          eval_s  = 1'b1;
          lu_ok_s = (state_r == ST_RUN);
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_done) begin
          eval_s      = 1'b1;
          lu_ok_s     = 1'b1;
          wait_next_s = {WAIT_W{1'b0}};
        end else begin
          mem_stall_s = 1'b1;
          wait_next_s = wait_cnt_r + 1'b1;
          if (wait_cnt_r == WAIT_LAST) begin
            timeout_s = 1'b1;
          end else begin
            timeout_s = 1'b0;
          end
        end
      end
      ST_FLUSH: begin
        if (bus.mem_req && !bus.mem_done) begin
          mem_stall_s = 1'b1;
          wait_next_s = {WAIT_W{1'b0}};
        end else begin
          mem_stall_s = 1'b0;
        end
      end
      default: begin
        mem_stall_s = 1'b0;
      end
    endcase
  end

  // Fixed priority MEM > branch > load-use; everything is silenced in reset.
  always_comb begin
    stall_s      = STALL_NONE;
    flush_s      = 1'b0;
    redirect_s   = 1'b0;
    new_pc_s     = {ADDR_W{1'b0}};
    state_next_s = ST_RUN;
    if (!rst) begin
      state_next_s = ST_RUN;
    end else if (mem_stall_s) begin
      stall_s      = STALL_MEM;
      state_next_s = timeout_s ? ST_RUN : ST_MEM_WAIT;
    end else if (eval_s && bus.ex_branch_req) begin
      flush_s      = 1'b1;
      redirect_s   = 1'b1;
      new_pc_s     = bus.ex_branch_target;
      state_next_s = ST_FLUSH;
    end else if (eval_s && lu_ok_s && bus.id_load_use_req) begin
      stall_s      = STALL_LU;
      state_next_s = ST_BUBBLE;
    end else begin
      state_next_s = ST_RUN;
    end
  end

  // FSM state, wait counter and the registered status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
      ignore_r   <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_next_s;
      ignore_r   <= (state_next_s == ST_FLUSH);
      timeout_r  <= timeout_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s[0] && !(&stall_cnt_r)) begin
        stall_cnt_r <= stall_cnt_r + 1'b1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && !(&flush_cnt_r)) begin
        flush_cnt_r <= flush_cnt_r + 1'b1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.stall_o       = stall_s;
  assign bus.flush_o       = flush_s;
  assign bus.pc_redirect_o = redirect_s;
  assign bus.new_pc_o      = new_pc_s;
  assign bus.ignore_o      = ignore_r;
  assign bus.mem_timeout_o = timeout_r;
  assign state_o           = state_r;
  assign stall_cnt_o       = stall_cnt_r;
  assign flush_cnt_o       = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand-written timeout/reset
// sequences, then random traffic against a behavioural reference model.
module tb_pipe_ctrl;

  localparam int MEM_TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  pipe_ctrl_if #(.ADDR_W(32)) bus ();

  pipe_ctrl #(.ADDR_W(32), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_o     (state_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // bundle: stall(6) flush redir pc(32) ignore timeout state(2) scnt(32) fcnt(32)
  typedef struct {
    bit          r, lu, br;
    logic [31:0] tgt;
    bit          mr, md;
    logic [5:0]  stall;
    bit          fl, rd;
    logic [31:0] pc;
    bit          ig, to;
    logic [1:0]  st;
    logic [31:0] sc, fc;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(bit r, bit lu, bit br, logic [31:0] tgt, bit mr, bit md,
                              logic [5:0] stall, bit fl, bit rd, logic [31:0] pc,
                              bit ig, bit to, logic [1:0] st, logic [31:0] sc, logic [31:0] fc);
    vec_t v;
    v.r = r; v.lu = lu; v.br = br; v.tgt = tgt; v.mr = mr; v.md = md;
    v.stall = stall; v.fl = fl; v.rd = rd; v.pc = pc; v.ig = ig; v.to = to;
    v.st = st; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  // Reference model: pipeline condition described by "what happened last cycle".
  bit          m_waiting;
  int          m_waited;
  bit          m_after_flush, m_after_lu, m_timeout;
  longint      m_scnt, m_fcnt;
  logic [107:0] m_exp;

  task automatic model_reset();
    m_waiting = 1'b0; m_waited = 0; m_after_flush = 1'b0; m_after_lu = 1'b0;
    m_timeout = 1'b0; m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic model_step(input bit r, input bit lu, input bit br, input logic [31:0] tgt,
                            input bit mr, input bit md);
    logic [5:0]  stall = 6'd0;
    bit          fl = 1'b0, decide = 1'b0, lu_ok = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [1:0]  st;
    bit          n_wait = 1'b0, n_af = 1'b0, n_alu = 1'b0, n_to = 1'b0;
    int          n_waited = 0;
    st = m_waiting ? 2'd1 : m_after_flush ? 2'd2 : m_after_lu ? 2'd3 : 2'd0;
    if (r) begin
      if (m_waiting) begin
        if (md) begin
          decide = 1'b1; lu_ok = 1'b1;
        end else begin
          stall = 6'h0F; n_waited = m_waited + 1;
          if (n_waited >= MEM_TIMEOUT) n_to = 1'b1;
          else n_wait = 1'b1;
        end
      end else if (mr && !md) begin
        stall = 6'h0F; n_wait = 1'b1; n_waited = 1;
      end else if (!m_after_flush) begin
        decide = 1'b1; lu_ok = !m_after_lu;
      end
      if (decide && br) begin
        fl = 1'b1; pc = tgt; n_af = 1'b1;
      end else if (decide && lu && lu_ok) begin
        stall = 6'h03; n_alu = 1'b1;
      end
    end
    m_exp = {stall, fl, fl, pc, m_after_flush, m_timeout, st, m_scnt[31:0], m_fcnt[31:0]};
    if (!r) begin
      model_reset();
    end else begin
      if (stall[0] && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (fl && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
      m_waiting = n_wait; m_waited = n_waited; m_after_flush = n_af;
      m_after_lu = n_alu; m_timeout = n_to;
    end
  endtask

  function automatic logic [107:0] actual();
    return {bus.stall_o, bus.flush_o, bus.pc_redirect_o, bus.new_pc_o, bus.ignore_o,
            bus.mem_timeout_o, state_o, stall_cnt_o, flush_cnt_o};
  endfunction

  task automatic check(input string name, input logic [107:0] act, input logic [107:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, settle 1 time unit, advance the model.
  task automatic drive(input bit r, input bit lu, input bit br, input logic [31:0] tgt,
                       input bit mr, input bit md);
    rst = r;
    bus.id_load_use_req = lu; bus.ex_branch_req = br; bus.ex_branch_target = tgt;
    bus.mem_req = mr; bus.mem_done = md;
    #1;
    model_step(r, lu, br, tgt, mr, md);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mk(0,1,1,32'h40,1,0,      6'h00,0,0,32'h0,       0,0,2'd0,32'd0,32'd0);
    vecs[1]  = mk(0,1,1,32'h40,1,0,      6'h00,0,0,32'h0,       0,0,2'd0,32'd0,32'd0);
    vecs[2]  = mk(1,1,0,32'h0,0,0,       6'h03,0,0,32'h0,       0,0,2'd0,32'd0,32'd0);
    vecs[3]  = mk(1,1,0,32'h0,0,0,       6'h00,0,0,32'h0,       0,0,2'd3,32'd1,32'd0);
    vecs[4]  = mk(1,0,0,32'h0,0,0,       6'h00,0,0,32'h0,       0,0,2'd0,32'd1,32'd0);
    vecs[5]  = mk(1,0,1,32'h40,0,0,      6'h00,1,1,32'h40,      0,0,2'd0,32'd1,32'd0);
    vecs[6]  = mk(1,0,0,32'h0,0,0,       6'h00,0,0,32'h0,       1,0,2'd2,32'd1,32'd1);
    vecs[7]  = mk(1,0,0,32'h0,0,0,       6'h00,0,0,32'h0,       0,0,2'd0,32'd1,32'd1);
    vecs[8]  = mk(1,0,0,32'h0,1,0,       6'h0F,0,0,32'h0,       0,0,2'd0,32'd1,32'd1);
    vecs[9]  = mk(1,0,0,32'h0,1,0,       6'h0F,0,0,32'h0,       0,0,2'd1,32'd2,32'd1);
    vecs[10] = mk(1,0,0,32'h0,1,0,       6'h0F,0,0,32'h0,       0,0,2'd1,32'd3,32'd1);
    vecs[11] = mk(1,0,0,32'h0,1,0,       6'h0F,0,0,32'h0,       0,0,2'd1,32'd4,32'd1);
    vecs[12] = mk(1,0,1,32'h12345678,1,1,6'h00,1,1,32'h12345678,0,0,2'd1,32'd5,32'd1);
    vecs[13] = mk(1,1,1,32'hABC,0,0,     6'h00,0,0,32'h0,       1,0,2'd2,32'd5,32'd2);
    vecs[14] = mk(1,1,0,32'h0,0,0,       6'h03,0,0,32'h0,       0,0,2'd0,32'd5,32'd2);
    vecs[15] = mk(1,1,1,32'h80,0,0,      6'h00,1,1,32'h80,      0,0,2'd3,32'd6,32'd2);
    vecs[16] = mk(1,0,0,32'h0,1,0,       6'h0F,0,0,32'h0,       1,0,2'd2,32'd6,32'd3);
    vecs[17] = mk(1,1,0,32'h0,1,1,       6'h03,0,0,32'h0,       0,0,2'd1,32'd7,32'd3);
    vecs[18] = mk(1,0,0,32'h0,0,0,       6'h00,0,0,32'h0,       0,0,2'd3,32'd8,32'd3);
    vecs[19] = mk(1,0,0,32'h0,1,1,       6'h00,0,0,32'h0,       0,0,2'd0,32'd8,32'd3);

    model_reset();
    drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
    tick();

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].r, vecs[i].lu, vecs[i].br, vecs[i].tgt, vecs[i].mr, vecs[i].md);
      check($sformatf("vec%0d", i), actual(),
            {vecs[i].stall, vecs[i].fl, vecs[i].rd, vecs[i].pc, vecs[i].ig, vecs[i].to,
             vecs[i].st, vecs[i].sc, vecs[i].fc});
      tick();
    end

    // Timeout: 15 stall cycles, then a one-cycle pulse back in RUN.
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      check($sformatf("to_stall%0d", i), 108'(bus.stall_o), 108'(6'h0F));
      check($sformatf("to_state%0d", i), 108'(state_o), 108'((i == 0) ? 2'd0 : 2'd1));
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("to_pulse", 108'({bus.mem_timeout_o, state_o, bus.stall_o}), 108'({1'b1, 2'd0, 6'h00}));
    check("to_scnt", 108'(stall_cnt_o), 108'(32'd23));
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("to_once", 108'(bus.mem_timeout_o), 108'(1'b0));
    tick();

    // Reset arriving on the third MEM_WAIT cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 32'h99, 1'b1, 1'b0);
    check("rst_wait_comb", 108'({bus.stall_o, bus.flush_o, bus.pc_redirect_o, bus.new_pc_o}), 108'(0));
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_wait_regs", 108'({state_o, bus.mem_timeout_o, stall_cnt_o}), 108'(0));
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            $urandom(), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
      check($sformatf("rnd%0d", i), actual(), m_exp);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
